// File: rtl/complex_fir_sample_feeder_pkg.sv
// Shared definitions for the complex FIR sample feeder: FSM encoding, width defaults
// and small elaboration-time helpers.
package complex_fir_sample_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_PAD    = 3'd3,
        ST_STOP   = 3'd4
    } feeder_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold values 0..maxval inclusive.
    function automatic int cnt_width(input int maxval);
        int w;
        w = $clog2(maxval + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/complex_fir_sample_feeder_ram.sv
// Complex sample buffer: DEPTH entries of {Re, Im}, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module complex_sample_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                         clock,
    input  logic                         we_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_i,
    input  logic signed [DATA_WIDTH-1:0] wdata_re_i,
    input  logic signed [DATA_WIDTH-1:0] wdata_im_i,
    input  logic [ADDR_WIDTH-1:0]        raddr_i,
    output logic signed [DATA_WIDTH-1:0] rdata_re_o,
    output logic signed [DATA_WIDTH-1:0] rdata_im_o
);

    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wdata_re_i, wdata_im_i};
        end
    end

    assign rdata_re_o = mem_q[raddr_i][2*DATA_WIDTH-1:DATA_WIDTH];
    assign rdata_im_o = mem_q[raddr_i][DATA_WIDTH-1:0];

endmodule

// File: rtl/complex_fir_sample_feeder.sv
// Feeds stored complex samples into n_tap_complex_fir: lead-in zeros, the samples,
// LENGTH-1 flush zeros, then a single stop cycle. All outputs are registered.
module complex_fir_sample_feeder
    import complex_fir_sample_feeder_pkg::*;
#(
    parameter int LENGTH      = 12,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int LEAD_CYCLES = 5
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         writeEnable,
    input  logic [ADDR_WIDTH-1:0]        writeAddr,
    input  logic signed [DATA_WIDTH-1:0] writeDataRe,
    input  logic signed [DATA_WIDTH-1:0] writeDataIm,
    input  logic [ADDR_WIDTH:0]          numSamples,
    input  logic                         startFlag,
    input  logic                         coefficientsSetFlag,
    output logic                         busy,
    output logic                         doneFlag,
    output logic                         loadDataFlag,
    output logic                         stopDataLoadFlag,
    output logic signed [DATA_WIDTH-1:0] dataOutRe,
    output logic signed [DATA_WIDTH-1:0] dataOutIm
);

    localparam int CNT_MAX = max3(LEAD_CYCLES, DEPTH, LENGTH - 1);
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0]    LEAD_LAST = CNT_W'(LEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    PAD_LAST  = CNT_W'(LENGTH - 2);
    localparam logic [ADDR_WIDTH:0] DEPTH_N   = (ADDR_WIDTH + 1)'(DEPTH);

    feeder_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH:0] nlat_q, nlat_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic load_q, load_d;
    logic stop_q, stop_d;
    logic signed [DATA_WIDTH-1:0] re_q, re_d;
    logic signed [DATA_WIDTH-1:0] im_q, im_d;

    logic signed [DATA_WIDTH-1:0] ram_re, ram_im;
    logic [CNT_W-1:0]             stream_last;
    logic                         ram_we;

    // The buffer is frozen while a transfer is in flight so the sent data is stable.
    assign ram_we      = writeEnable & ~busy_q;
    assign stream_last = CNT_W'(nlat_q) - CNT_W'(1);

    complex_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock      (clock),
        .we_i       (ram_we),
        .waddr_i    (writeAddr),
        .wdata_re_i (writeDataRe),
        .wdata_im_i (writeDataIm),
        .raddr_i    (cnt_d[ADDR_WIDTH-1:0]),
        .rdata_re_o (ram_re),
        .rdata_im_o (ram_im)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nlat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nlat_q  <= nlat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nlat_d  = nlat_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (startFlag && coefficientsSetFlag) begin
                    state_d = ST_LEAD;
                    nlat_d  = (numSamples > DEPTH_N) ? DEPTH_N : numSamples;
                end
            end
            ST_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (nlat_q == '0) ? ST_PAD : ST_STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STREAM: begin
                if (cnt_q == stream_last) begin
                    cnt_d   = '0;
                    state_d = ST_PAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PAD: begin
                if (cnt_q == PAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in the same cycle the state does.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP);
        stop_d = (state_d == ST_STOP);
        load_d = (state_d == ST_LEAD) || (state_d == ST_STREAM) || (state_d == ST_PAD);
        re_d   = '0;
        im_d   = '0;
        if (state_d == ST_STREAM) begin
            re_d = ram_re;
            im_d = ram_im;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            load_q <= 1'b0;
            stop_q <= 1'b0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            load_q <= load_d;
            stop_q <= stop_d;
            re_q   <= re_d;
            im_q   <= im_d;
        end
    end

    assign busy             = busy_q;
    assign doneFlag         = done_q;
    assign loadDataFlag     = load_q;
    assign stopDataLoadFlag = stop_q;
    assign dataOutRe        = re_q;
    assign dataOutIm        = im_q;

endmodule

// File: tb/tb_complex_fir_sample_feeder.sv
// Scoreboard bench for complex_fir_sample_feeder: per-cycle expected outputs are queued
// when a start is accepted and compared on every falling clock edge.
module tb_complex_fir_sample_feeder;

    localparam int LENGTH      = 12;
    localparam int DATA_WIDTH  = 8;
    localparam int DEPTH       = 64;
    localparam int ADDR_WIDTH  = 6;
    localparam int LEAD_CYCLES = 5;

    logic                         clock;
    logic                         resetN;
    logic                         writeEnable;
    logic [ADDR_WIDTH-1:0]        writeAddr;
    logic signed [DATA_WIDTH-1:0] writeDataRe;
    logic signed [DATA_WIDTH-1:0] writeDataIm;
    logic [ADDR_WIDTH:0]          numSamples;
    logic                         startFlag;
    logic                         coefficientsSetFlag;
    logic                         busy;
    logic                         doneFlag;
    logic                         loadDataFlag;
    logic                         stopDataLoadFlag;
    logic signed [DATA_WIDTH-1:0] dataOutRe;
    logic signed [DATA_WIDTH-1:0] dataOutIm;

    complex_fir_sample_feeder #(
        .LENGTH      (LENGTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .LEAD_CYCLES (LEAD_CYCLES)
    ) dut (
        .clock               (clock),
        .resetN              (resetN),
        .writeEnable         (writeEnable),
        .writeAddr           (writeAddr),
        .writeDataRe         (writeDataRe),
        .writeDataIm         (writeDataIm),
        .numSamples          (numSamples),
        .startFlag           (startFlag),
        .coefficientsSetFlag (coefficientsSetFlag),
        .busy                (busy),
        .doneFlag            (doneFlag),
        .loadDataFlag        (loadDataFlag),
        .stopDataLoadFlag    (stopDataLoadFlag),
        .dataOutRe           (dataOutRe),
        .dataOutIm           (dataOutIm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    // Expected word per cycle: {busy, done, load, stop, re, im}
    logic [19:0] exp_q [$];
    logic [15:0] mem_m [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] outs();
        return {busy, doneFlag, loadDataFlag, stopDataLoadFlag, dataOutRe, dataOutIm};
    endfunction

    always @(negedge clock) begin
        logic [19:0] e;
        if (mon_en) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("cycle_out", {12'h0, outs()}, {12'h0, e});
        end
    end

    task automatic push_xfer(input int n);
        int nlat;
        nlat = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < LEAD_CYCLES; i++) exp_q.push_back({4'b1010, 16'h0000});
        for (int k = 0; k < nlat; k++)        exp_q.push_back({4'b1010, mem_m[k]});
        for (int i = 0; i < LENGTH - 1; i++)  exp_q.push_back({4'b1010, 16'h0000});
        exp_q.push_back({4'b1101, 16'h0000});
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic we, input int addr, input int re, input int im,
                        input logic st, input logic coef, input int n);
        logic idle, acc, wr;
        logic [31:0] a, r, m, nn;
        a = addr; r = re; m = im; nn = n;
        writeEnable         = we;
        writeAddr           = a[ADDR_WIDTH-1:0];
        writeDataRe         = r[7:0];
        writeDataIm         = m[7:0];
        startFlag           = st;
        coefficientsSetFlag = coef;
        numSamples          = nn[ADDR_WIDTH:0];
        idle = (exp_q.size() == 0);
        acc  = st && coef && idle;
        wr   = we && idle;
        @(posedge clock);
        #1;
        if (wr)  mem_m[a[ADDR_WIDTH-1:0]] = {r[7:0], m[7:0]};
        if (acc) push_xfer(n);
    endtask

    task automatic idle_step();
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0);
    endtask

    task automatic wr(input int addr, input int re, input int im);
        step(1'b1, addr, re, im, 1'b0, 1'b1, 0);
    endtask

    task automatic start(input int n);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1, n);
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            idle_step();
            budget--;
        end
        chk("drain_timeout", {31'h0, exp_q.size() > 0}, 32'h0);
    endtask

    initial begin
        resetN = 1'b0;
        writeEnable = 1'b0; writeAddr = '0; writeDataRe = '0; writeDataIm = '0;
        numSamples = '0; startFlag = 1'b0; coefficientsSetFlag = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", {12'h0, outs()}, 32'h0);
        resetN = 1'b1;
        mon_en = 1'b1;

        // Initialise the whole buffer so no stale entries are read.
        for (int i = 0; i < DEPTH; i++) wr(i, 0, 0);

        // Basic four-sample transfer.
        wr(0, 2, 3); wr(1, 5, 10); wr(2, -2, -3); wr(3, 0, -6);
        start(4);
        chk("t1_len", exp_q.size(), LEAD_CYCLES + 4 + LENGTH);
        drain();

        // 28-sample vector, coefficientsSetFlag dropped mid-transfer.
        for (int k = 0; k < 28; k++) wr(k, k * 7 - 90, 60 - k * 5);
        start(28);
        repeat (10) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        drain();

        // Zero-length transfer: lead-in, pad, stop.
        start(0);
        drain();

        // Oversized request clamps at DEPTH entries, no wrap back to entry 0.
        for (int k = 0; k < DEPTH; k++) wr(k, k + 1, -(k + 1));
        start(100);
        chk("t4_len", exp_q.size(), LEAD_CYCLES + DEPTH + LENGTH);
        drain();

        // Start ignored without coefficients.
        repeat (3) step(1'b0, 0, 0, 0, 1'b1, 1'b0, 5);
        #2;
        chk("t5_no_coef_busy", {31'h0, busy}, 32'h0);

        // Start and writes during busy are ignored; restart right after STOP.
        start(3);
        repeat (8) step(1'b1, 0, 77, 77, 1'b1, 1'b1, 9);
        drain();
        start(3);
        drain();

        // Asynchronous reset in STREAM while sample 2 is on the outputs.
        wr(2, -100, 99);
        start(4);
        repeat (LEAD_CYCLES + 2) idle_step();
        chk("t6_pre_rst_data", {16'h0, dataOutRe, dataOutIm}, {16'h0, mem_m[2]});
        resetN = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_rst", {12'h0, outs()}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        idle_step();
        start(4);
        drain();

        repeat (3) idle_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
